// File: rtl/apb_m_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_m_if
// Description : Command/response and APB bus bundle for the apb_m bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_m_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_m.sv
`default_nettype none
// ============================================================================
// Module      : apb_m
// Description : APB master bridge; valid/ready commands become SETUP/ACCESS
//               transfers with one response per command.
//               Define APB_M_TIMEOUT_EN to abort ACCESS after TIMEOUT waits.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_m #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
`ifdef APB_M_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic    pclk,
    input  logic    preset,
    apb_m_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_done;
    logic              w_abort;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;

    assign bus.cmd_ready = (r_state == IDLE) && !preset;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;

    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_write = r_rsp_write;
    assign bus.rsp_rdata = r_rsp_rdata;

`ifdef APB_M_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_wait_lim = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_rsp_err;

    // Counter value equals completed wait cycles of the current ACCESS phase,
    // so hitting the limit while pready is low marks the TIMEOUT-th cycle.
    assign w_abort     = (r_state == ACCESS) && !bus.pready && (r_wait_cnt == c_wait_lim);
    assign bus.rsp_err = r_rsp_err;

    always_ff @(posedge pclk) begin
        if (preset || (r_state != ACCESS)) begin
            r_wait_cnt <= '0;
        end else if (!bus.pready) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_abort;
        end
    end
`else
    assign w_abort     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                // pready wins over a simultaneous timeout
                if (bus.pready) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end else if (w_abort) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_psel      <= (w_state_next != IDLE);
            r_penable   <= (w_state_next == ACCESS);
            // Address/data only change on a handshake, so they hold while idle.
            if (w_accept) begin
                r_pwrite <= bus.cmd_write;
                r_paddr  <= bus.cmd_addr;
                r_pwdata <= bus.cmd_wdata;
            end
            r_rsp_valid <= w_done || w_abort;
            r_rsp_write <= (w_done || w_abort) ? r_pwrite : 1'b0;
            r_rsp_rdata <= (w_done && !r_pwrite) ? bus.prdata : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_m.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_m
// Description : Self-checking bench for apb_m against a memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_m;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
`ifdef APB_M_TIMEOUT_EN
    localparam int TIMEOUT = 15;
`endif

    logic pclk = 1'b0;
    logic preset = 1'b1;
    logic mem_init = 1'b1;
    always #5 pclk = ~pclk;

    apb_m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    apb_m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Slave memory (stimulus side) and reference memory (expected side)
    logic [7:0] slv_mem [16];
    logic [7:0] ref_mem [16];
    int         wait_req = 0;
    int         acc = 0;

    assign bus.pready = bus.psel && bus.penable && (acc >= wait_req);
    assign bus.prdata = slv_mem[bus.paddr];

    always @(posedge pclk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= 8'(i * 29) ^ 8'h5A;
        end else if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
            slv_mem[bus.paddr] <= bus.pwdata;
        end
        if (bus.psel && bus.penable && !bus.pready) acc <= acc + 1;
        else acc <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transfer from an idle negedge; returns at an idle negedge.
    task automatic xfer(input bit wr, input logic [3:0] a, input logic [7:0] d,
                        input int w, input bit noise);
        int cyc, ps, pe, eff;
        bit bad, err;
        logic [7:0] exp_rd;
        eff = w;
        err = 1'b0;
`ifdef APB_M_TIMEOUT_EN
        if (w > TIMEOUT - 1) begin
            eff = TIMEOUT - 1;
            err = 1'b1;
        end
`endif
        exp_rd = (wr || err) ? 8'h00 : ref_mem[a];
        if (wr && !err) ref_mem[a] = d;
        wait_req = w;
        chk("idle_ready", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        cyc = 1; ps = 0; pe = 0; bad = 1'b0;
        while (!bus.rsp_valid && cyc < 200) begin
            if (bus.psel) ps++;
            if (bus.penable) pe++;
            if (bus.psel && (bus.paddr !== a || bus.pwrite !== wr || (wr && bus.pwdata !== d)))
                bad = 1'b1;
            if (noise) begin
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_write = ~wr;
                bus.cmd_addr  = ~a;
                bus.cmd_wdata = ~d;
            end
            @(negedge pclk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        chk("latency", 32'(cyc), 32'(3 + eff));
        chk("psel_cycles", 32'(ps), 32'(2 + eff));
        chk("penable_cycles", 32'(pe), 32'(1 + eff));
        chk("bus_stable", 32'(bad), 0);
        chk("rsp_write", 32'(bus.rsp_write), 32'(wr));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(bus.rsp_err), 32'(err));
        chk("rsp_cycle_ready", 32'(bus.cmd_ready), 1);
        chk("rsp_cycle_psel", 32'(bus.psel), 0);
        @(negedge pclk);
        chk("single_pulse", 32'(bus.rsp_valid), 0);
        chk("no_capture", 32'(bus.psel), 0);
    endtask

    initial begin
        bit         bw [3];
        logic [3:0] ba [3];
        logic [7:0] bd [3];
        logic [7:0] exp_rd;
        logic [7:0] rd;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 29) ^ 8'h5A;
        repeat (3) @(negedge pclk);

        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst_psel", 32'(bus.psel), 0);
        chk("rst_penable", 32'(bus.penable), 0);
        chk("rst_bus", {bus.pwrite, bus.paddr, bus.pwdata}, 0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata}, 0);
        preset = 1'b0;
        mem_init = 1'b0;
        @(negedge pclk);

        xfer(1'b1, 4'd3, 8'hA5, 0, 1'b0);
        xfer(1'b0, 4'd3, 8'h00, 0, 1'b0);
        xfer(1'b0, 4'd7, 8'h00, 4, 1'b0);
        xfer(1'b1, 4'd5, 8'($urandom_range(0, 255)), 2, 1'b1);
        xfer(1'b0, 4'd5, 8'h00, 1, 1'b1);

        // Commands held valid back to back
        bw[0] = 1'b1; ba[0] = 4'd1; bd[0] = 8'h11;
        bw[1] = 1'b1; ba[1] = 4'd2; bd[1] = 8'h22;
        bw[2] = 1'b0; ba[2] = 4'd1; bd[2] = 8'h00;
        wait_req = 0;
        for (int i = 0; i < 3; i++) begin
            exp_rd = bw[i] ? 8'h00 : ref_mem[ba[i]];
            if (bw[i]) ref_mem[ba[i]] = bd[i];
            bus.cmd_valid = 1'b1;
            bus.cmd_write = bw[i];
            bus.cmd_addr  = ba[i];
            bus.cmd_wdata = bd[i];
            chk("b2b_ready", 32'(bus.cmd_ready), 1);
            @(negedge pclk);
            chk("b2b_setup", {bus.psel, bus.penable, bus.cmd_ready}, 32'b100);
            @(negedge pclk);
            chk("b2b_access", {bus.psel, bus.penable, bus.cmd_ready}, 32'b110);
            @(negedge pclk);
            chk("b2b_rsp", {bus.rsp_valid, bus.psel, bus.cmd_ready}, 32'b101);
            chk("b2b_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        end
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        chk("b2b_read_value", 32'(exp_rd), 32'h11);

        // Reset during the ACCESS phase of a write
        rd = ref_mem[9];
        wait_req = 3;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'd9;
        bus.cmd_wdata = ~rd;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        chk("mid_access", {bus.psel, bus.penable}, 32'b11);
        preset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.cmd_ready), 0);
        @(negedge pclk);
        chk("mid_rst_apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);
        chk("mid_rst_rsp", {bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata}, 0);
        preset = 1'b0;
        @(negedge pclk);
        chk("mid_rst_no_rsp", {bus.rsp_valid, bus.psel}, 0);
        xfer(1'b0, 4'd9, 8'h00, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

`ifdef APB_M_TIMEOUT_EN
        xfer(1'b0, 4'd4, 8'h00, 100, 1'b0);
        xfer(1'b1, 4'd4, 8'h3C, 100, 1'b0);
        xfer(1'b0, 4'd4, 8'h00, TIMEOUT - 1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/apb_m.md
Name: apb_m

Overview:
- APB master bridge that turns a simple valid/ready command interface into APB SETUP/ACCESS transfers.
- Drives the APB slave memory block and returns one response per command (read data or write completion).
- Sits directly upstream of the APB slave: the test sequencer or a CPU-side engine issues commands, and this block owns psel/penable/pwrite/paddr/pwdata.

Parameters:
- ADDR_W, 4, width of cmd_addr and paddr.
- DATA_W, 8, width of the write/read data paths.
- TIMEOUT, 15, ACCESS cycles without pready before abort (used only when APB_M_TIMEOUT_EN is defined).

Ports:
- pclk  in  1  clock; everything is on the rising edge.
- preset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_write  out  1  echo of the completed command type.
- rsp_rdata  out  DATA_W  read data; 0 for write responses.
- rsp_err  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.

Behaviour:
- Reset (preset=1 at a clock edge):
  - state=IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_write, rsp_rdata, rsp_err all 0.
  - cmd_ready forced 0 while preset=1.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1 (combinational from state and preset).
  - psel=0, penable=0.
  - A handshake (cmd_valid & cmd_ready) registers cmd_write/addr/wdata into pwrite/paddr/pwdata, then moves to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0; next state is always ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - If pready=0, stay in ACCESS (wait state).
  - If pready=1, the transfer completes: go to IDLE.
  - On completion, the next cycle shows rsp_valid=1, rsp_write=pwrite, rsp_rdata = prdata sampled at that edge for reads (0 for writes), rsp_err=0.
- Latency:
  - Command accepted at edge T: SETUP during T+1, ACCESS during T+2.
  - With zero wait states, rsp_valid and cmd_ready are both high in cycle T+3.
  - Minimum of 3 cycles per transfer; each wait state adds 1.
- Back-to-back: a new command may be accepted in the same cycle rsp_valid is high. The next SETUP then follows with psel dropping for exactly one cycle (IDLE).
- rsp_valid is a single-cycle pulse with no backpressure; the consumer must take it.
- paddr/pwrite/pwdata:
  - Stable from SETUP through the final ACCESS cycle.
  - Retain their last values while IDLE (no toggling).
- cmd_valid while busy (not IDLE) is ignored: no capture and no queuing.
- Reset mid-transfer: at the next edge psel/penable go to 0 and state goes to IDLE; the transfer is dropped with no rsp_valid.
- Outputs are registered except cmd_ready.

Optional Feature:
- APB_M_TIMEOUT_EN defined:
  - An ACCESS wait counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT, the master aborts: psel=penable=0 and state=IDLE.
  - The next cycle shows rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - pready arriving in the same cycle as the limit wins: normal completion, rsp_err=0.
- Not defined:
  - No counter; the master waits indefinitely for pready.
  - rsp_err is tied to 0.

Test Plan:
- Write addr 3, data 0xA5, slave zero-wait, then read addr 3 -> psel high for 2 cycles per transfer; write response rsp_err=0, rsp_rdata=0; read response rsp_rdata=0xA5, each at T+3.
- Read addr 7 with slave holding pready low for 4 ACCESS cycles -> penable high for 5 cycles, paddr stable at 7, rsp_valid exactly once at T+7.
- Commands held valid continuously (write 1/0x11, write 2/0x22, read 1) -> cmd_ready pulses once every 3 cycles, psel drops for 1 cycle between transfers, read returns 0x11.
- cmd_valid toggled during SETUP/ACCESS with different addr -> not captured; paddr unchanged; only one response.
- preset asserted during ACCESS of a write -> next cycle psel=0, penable=0, all outputs 0, no rsp_valid; the next command after release behaves normally.
- APB_M_TIMEOUT_EN, TIMEOUT=15, pready stuck low -> abort after 15 ACCESS cycles, rsp_err=1, rsp_rdata=0. Repeat with pready rising on the 15th cycle -> rsp_err=0.
